// File: rtl/mouse_receiver_if.sv
// Byte-level handshake between the PS/2 mouse receiver and the mouse master state machine.
interface mouse_receiver_if;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BYTE_READY;

  modport master (
    output READ_ENABLE,
    input  BYTE_READ,
    input  BYTE_ERROR_CODE,
    input  BYTE_READY
  );

  modport slave (
    input  READ_ENABLE,
    output BYTE_READ,
    output BYTE_ERROR_CODE,
    output BYTE_READY
  );
endinterface

// File: rtl/mouse_receiver.sv
// PS/2 device-to-host receiver: synchronises the mouse CLK/DATA lines and deframes one
// 11-bit frame (start, 8 data LSB-first, odd parity, stop) into a byte plus error flags.
module mouse_receiver #(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int CNT_W          = 13
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            CLK_MOUSE_IN,
  input  logic            DATA_MOUSE_IN,
  mouse_receiver_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_r;
  logic [1:0]       clk_sync_r;
  logic [1:0]       data_sync_r;
  logic             clk_prev_r;
  logic [2:0]       bit_cnt_r;
  logic [7:0]       shreg_r;
  logic             parity_r;
  logic [CNT_W-1:0] timeout_r;
  logic [7:0]       byte_read_r;
  logic [1:0]       byte_error_code_r;
  logic             byte_ready_r;
  logic             fe_s;
  logic             data_s;
  logic             timeout_hit_s;

  // Odd parity: data ones plus parity bit must be odd, otherwise flag an error.
  function automatic logic parity_error(input logic [7:0] data, input logic parity);
    return ~((^data) ^ parity);
  endfunction

  // Two-flop synchronisers plus the previous synchronised clock for edge detection
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      clk_sync_r  <= 2'b11;
      data_sync_r <= 2'b11;
      clk_prev_r  <= 1'b1;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], CLK_MOUSE_IN};
      data_sync_r <= {data_sync_r[0], DATA_MOUSE_IN};
      clk_prev_r  <= clk_sync_r[1];
    end
  end

  assign fe_s          = clk_prev_r & ~clk_sync_r[1];
  assign data_s        = data_sync_r[1];
  assign timeout_hit_s = (timeout_r == TERM_CNT);

  // Frame sequencer with inter-edge timeout; outputs load on the stop bit so they are valid in DONE
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r           <= IDLE;
      bit_cnt_r         <= 3'd0;
      shreg_r           <= 8'h00;
      parity_r          <= 1'b0;
      timeout_r         <= '0;
      byte_read_r       <= 8'h00;
      byte_error_code_r <= 2'b00;
      byte_ready_r      <= 1'b0;
    end else begin
      byte_ready_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (fe_s && bus.READ_ENABLE && !data_s) begin
            state_r   <= DATA;
            bit_cnt_r <= 3'd0;
            timeout_r <= '0;
          end else begin
            state_r <= IDLE;
          end
        end
        DATA: begin
          if (fe_s) begin
            timeout_r          <= '0;
            shreg_r[bit_cnt_r] <= data_s;
            if (bit_cnt_r == 3'd7) begin
              state_r <= PARITY;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end else if (timeout_hit_s) begin
            state_r <= IDLE;
          end else begin
            timeout_r <= timeout_r + CNT_W'(1);
          end
        end
        PARITY: begin
          if (fe_s) begin
            timeout_r <= '0;
            parity_r  <= data_s;
            state_r   <= STOP;
          end else if (timeout_hit_s) begin
            state_r <= IDLE;
          end else begin
            timeout_r <= timeout_r + CNT_W'(1);
          end
        end
        STOP: begin
          if (fe_s) begin
            timeout_r         <= '0;
            byte_read_r       <= shreg_r;
            byte_error_code_r <= {~data_s, parity_error(shreg_r, parity_r)};
            byte_ready_r      <= 1'b1;
            state_r           <= DONE;
          end else if (timeout_hit_s) begin
            state_r <= IDLE;
          end else begin
            timeout_r <= timeout_r + CNT_W'(1);
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.BYTE_READ       = byte_read_r;
  assign bus.BYTE_ERROR_CODE = byte_error_code_r;
  assign bus.BYTE_READY      = byte_ready_r;
endmodule
